// File: rtl/pwm_seq_pkg.sv
// Shared definitions for the PWM duty-table sequencer: FSM encoding,
// slave register offsets and the interval clamp helper.
package pwm_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_WAIT = 2'd3
    } state_e;

    localparam logic [15:0] OFF_CTRL     = 16'h0000;
    localparam logic [15:0] OFF_INTERVAL = 16'h0004;
    localparam logic [15:0] OFF_LEN      = 16'h0008;
    localparam logic [15:0] OFF_STATUS   = 16'h000C;
    localparam logic [15:0] OFF_TABLE    = 16'h0040;

    // A zero interval still spends one cycle in WAIT.
    function automatic logic [31:0] eff_interval(input logic [31:0] ivl);
        return (ivl == 32'd0) ? 32'd1 : ivl;
    endfunction

endpackage

// File: rtl/pwm_seq_regs.sv
// Slave-side decode, control/status registers and the duty table for pwm_seq.
// Accesses are always full-word; the byte mask and slave ready are not used.
module pwm_seq_regs
    import pwm_seq_pkg::*;
#(
    parameter int TBL_DEPTH = 8,
    parameter int IDX_W     = 3
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [31:0]      i_ribs_addr,
    input  logic             i_ribs_wrcs,
    input  logic [3:0]       i_ribs_mask,
    input  logic [31:0]      i_ribs_wdata,
    output logic [31:0]      o_ribs_rdata,
    input  logic             i_ribs_req,
    output logic             o_ribs_gnt,
    output logic             o_ribs_rsp,
    input  logic             i_ribs_rdy,
    input  logic             i_busy,
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_done_set,
    input  logic             i_en_clr,
    input  logic [IDX_W-1:0] i_tbl_idx,
    output logic [31:0]      o_tbl_data,
    output logic             o_en,
    output logic             o_loop,
    output logic             o_ie,
    output logic [31:0]      o_interval,
    output logic [3:0]       o_len,
    output logic             o_done
);

    logic [2:0]       ctrl_q, ctrl_d;
    logic [31:0]      interval_q, interval_d;
    logic [3:0]       len_q, len_d;
    logic             done_q, done_d;
    logic [31:0]      tbl_q [TBL_DEPTH];
    logic [31:0]      tbl_d [TBL_DEPTH];
    logic             rsp_q, rsp_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [15:0]      addr_al;
    logic [13:0]      tbl_word;
    logic             tbl_hit;
    logic [IDX_W-1:0] tbl_acc_idx;
    logic [2:0]       idx3;
    logic             wr_en;
    logic [31:0]      rd_mux;
    logic             unused_ok;

    assign addr_al     = {i_ribs_addr[15:2], 2'b00};
    assign tbl_word    = i_ribs_addr[15:2] - OFF_TABLE[15:2];
    assign tbl_hit     = (addr_al >= OFF_TABLE) && ({18'd0, tbl_word} < 32'(TBL_DEPTH));
    assign tbl_acc_idx = tbl_word[IDX_W-1:0];
    assign idx3        = 3'(i_idx);
    assign wr_en       = i_ribs_req & i_ribs_wrcs;
    assign unused_ok   = ^{i_ribs_addr[31:16], i_ribs_addr[1:0], i_ribs_mask, i_ribs_rdy};

    always_comb begin
        ctrl_d     = ctrl_q;
        interval_d = interval_q;
        len_d      = len_q;
        done_d     = done_q;
        tbl_d      = tbl_q;
        if (wr_en) begin
            if (addr_al == OFF_CTRL) begin
                ctrl_d = i_ribs_wdata[2:0];
            end else if (addr_al == OFF_INTERVAL) begin
                interval_d = i_ribs_wdata;
            end else if (addr_al == OFF_LEN) begin
                len_d = i_ribs_wdata[3:0];
            end else if (addr_al == OFF_STATUS) begin
                if (i_ribs_wdata[1]) done_d = 1'b0;
            end else if (tbl_hit) begin
                tbl_d[tbl_acc_idx] = i_ribs_wdata;
            end
        end
        // Sequencer events override a coincident software write.
        if (i_en_clr)   ctrl_d[0] = 1'b0;
        if (i_done_set) done_d    = 1'b1;
    end

    always_comb begin
        rd_mux = 32'd0;
        if (addr_al == OFF_CTRL)          rd_mux = {29'd0, ctrl_q};
        else if (addr_al == OFF_INTERVAL) rd_mux = interval_q;
        else if (addr_al == OFF_LEN)      rd_mux = {28'd0, len_q};
        else if (addr_al == OFF_STATUS)   rd_mux = {25'd0, idx3, 2'b00, done_q, i_busy};
        else if (tbl_hit)                 rd_mux = tbl_q[tbl_acc_idx];
        rsp_d   = i_ribs_req;
        rdata_d = (i_ribs_req && !i_ribs_wrcs) ? rd_mux : 32'd0;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ctrl_q     <= '0;
            interval_q <= '0;
            len_q      <= '0;
            done_q     <= 1'b0;
            rsp_q      <= 1'b0;
            rdata_q    <= '0;
            for (int i = 0; i < TBL_DEPTH; i++) tbl_q[i] <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            interval_q <= interval_d;
            len_q      <= len_d;
            done_q     <= done_d;
            rsp_q      <= rsp_d;
            rdata_q    <= rdata_d;
            for (int i = 0; i < TBL_DEPTH; i++) tbl_q[i] <= tbl_d[i];
        end
    end

    assign o_ribs_gnt   = i_ribs_req;
    assign o_ribs_rsp   = rsp_q;
    assign o_ribs_rdata = rdata_q;
    assign o_tbl_data   = tbl_q[i_tbl_idx];
    assign o_en         = ctrl_q[0];
    assign o_loop       = ctrl_q[1];
    assign o_ie         = ctrl_q[2];
    assign o_interval   = interval_q;
    assign o_len        = len_q;
    assign o_done       = done_q;

endmodule

// File: rtl/pwm_seq.sv
// PWM duty sequencer: walks the duty table and writes each entry to the PWM
// compare register over the master bus, pausing INTERVAL cycles between writes.
module pwm_seq
    import pwm_seq_pkg::*;
#(
    parameter int          TBL_DEPTH    = 8,
    parameter logic [31:0] PWM_CMP_ADDR = 32'h0000_0008
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [31:0] i_ribs_addr,
    input  logic        i_ribs_wrcs,
    input  logic [3:0]  i_ribs_mask,
    input  logic [31:0] i_ribs_wdata,
    output logic [31:0] o_ribs_rdata,
    input  logic        i_ribs_req,
    output logic        o_ribs_gnt,
    output logic        o_ribs_rsp,
    input  logic        i_ribs_rdy,
    output logic [31:0] o_ribm_addr,
    output logic        o_ribm_wrcs,
    output logic [3:0]  o_ribm_mask,
    output logic [31:0] o_ribm_wdata,
    input  logic [31:0] i_ribm_rdata,
    output logic        o_ribm_req,
    input  logic        i_ribm_gnt,
    input  logic        i_ribm_rsp,
    output logic        o_ribm_rdy,
    output logic        o_irq
);

    localparam int IDX_W = (TBL_DEPTH > 1) ? $clog2(TBL_DEPTH) : 1;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [31:0]      ivl_q, ivl_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             en_prev_q, en_prev_d;

    logic             en, loop, ie, done;
    logic [31:0]      interval;
    logic [3:0]       len;
    logic [4:0]       eff_len;
    logic             last;
    logic             done_set, en_clr, load_req;
    logic [31:0]      tbl_data;
    logic             unused_rdata;

    assign unused_rdata = ^i_ribm_rdata;

    pwm_seq_regs #(
        .TBL_DEPTH (TBL_DEPTH),
        .IDX_W     (IDX_W)
    ) u_regs (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_ribs_addr  (i_ribs_addr),
        .i_ribs_wrcs  (i_ribs_wrcs),
        .i_ribs_mask  (i_ribs_mask),
        .i_ribs_wdata (i_ribs_wdata),
        .o_ribs_rdata (o_ribs_rdata),
        .i_ribs_req   (i_ribs_req),
        .o_ribs_gnt   (o_ribs_gnt),
        .o_ribs_rsp   (o_ribs_rsp),
        .i_ribs_rdy   (i_ribs_rdy),
        .i_busy       (state_q != ST_IDLE),
        .i_idx        (idx_q),
        .i_done_set   (done_set),
        .i_en_clr     (en_clr),
        .i_tbl_idx    (idx_d),
        .o_tbl_data   (tbl_data),
        .o_en         (en),
        .o_loop       (loop),
        .o_ie         (ie),
        .o_interval   (interval),
        .o_len        (len),
        .o_done       (done)
    );

    always_comb begin
        if (len == 4'd0)                         eff_len = 5'd1;
        else if (32'(len) > 32'(TBL_DEPTH))      eff_len = 5'(TBL_DEPTH);
        else                                     eff_len = {1'b0, len};
    end

    // LEN is sampled live at each compare; >= covers a LEN shrunk mid-run.
    assign last = (5'(idx_q) + 5'd1) >= eff_len;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        ivl_d     = ivl_q;
        en_prev_d = en;
        done_set  = 1'b0;
        en_clr    = 1'b0;
        load_req  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (en && !en_prev_q) begin
                    state_d  = ST_REQ;
                    idx_d    = '0;
                    load_req = 1'b1;
                end
            end
            ST_REQ: begin
                if (i_ribm_gnt) state_d = ST_RSP;
            end
            ST_RSP: begin
                if (i_ribm_rsp) begin
                    if (!en) begin
                        state_d = ST_IDLE;
                    end else if (last && !loop) begin
                        state_d  = ST_IDLE;
                        done_set = 1'b1;
                        en_clr   = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        idx_d   = last ? '0 : idx_q + IDX_W'(1);
                        cnt_d   = 32'd0;
                        ivl_d   = eff_interval(interval);
                    end
                end
            end
            ST_WAIT: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (cnt_q >= ivl_q - 32'd1) begin
                    state_d  = ST_REQ;
                    load_req = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Table entry is captured on REQ entry so the bus payload stays put until granted.
    always_comb begin
        wdata_d = load_req ? tbl_data : wdata_q;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            ivl_q     <= '0;
            wdata_q   <= '0;
            en_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            ivl_q     <= ivl_d;
            wdata_q   <= wdata_d;
            en_prev_q <= en_prev_d;
        end
    end

    assign o_ribm_req   = (state_q == ST_REQ);
    assign o_ribm_addr  = o_ribm_req ? PWM_CMP_ADDR : 32'd0;
    assign o_ribm_wrcs  = o_ribm_req;
    assign o_ribm_mask  = o_ribm_req ? 4'hF : 4'h0;
    assign o_ribm_wdata = o_ribm_req ? wdata_q : 32'd0;
    assign o_ribm_rdy   = (state_q == ST_RSP);
    assign o_irq        = done & ie;

endmodule

// File: tb/tb_pwm_seq.sv
// Bench for pwm_seq: randomized duty sequences against a transaction-level
// model of the expected compare-register writes and inter-write spacing.
module tb_pwm_seq;

    localparam logic [31:0] A_CTRL   = 32'h000;
    localparam logic [31:0] A_IVL    = 32'h004;
    localparam logic [31:0] A_LEN    = 32'h008;
    localparam logic [31:0] A_STATUS = 32'h00C;
    localparam logic [31:0] A_TABLE  = 32'h040;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [31:0] i_ribs_addr = '0;
    logic        i_ribs_wrcs = 1'b0;
    logic [3:0]  i_ribs_mask = 4'h0;
    logic [31:0] i_ribs_wdata = '0;
    logic [31:0] o_ribs_rdata;
    logic        i_ribs_req = 1'b0;
    logic        o_ribs_gnt;
    logic        o_ribs_rsp;
    logic        i_ribs_rdy = 1'b1;
    logic [31:0] o_ribm_addr;
    logic        o_ribm_wrcs;
    logic [3:0]  o_ribm_mask;
    logic [31:0] o_ribm_wdata;
    logic [31:0] i_ribm_rdata = '0;
    logic        o_ribm_req;
    logic        i_ribm_gnt = 1'b0;
    logic        i_ribm_rsp = 1'b0;
    logic        o_ribm_rdy;
    logic        o_irq;

    pwm_seq #(.TBL_DEPTH(8), .PWM_CMP_ADDR(32'h0000_0008)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_ribs_addr(i_ribs_addr), .i_ribs_wrcs(i_ribs_wrcs), .i_ribs_mask(i_ribs_mask),
        .i_ribs_wdata(i_ribs_wdata), .o_ribs_rdata(o_ribs_rdata), .i_ribs_req(i_ribs_req),
        .o_ribs_gnt(o_ribs_gnt), .o_ribs_rsp(o_ribs_rsp), .i_ribs_rdy(i_ribs_rdy),
        .o_ribm_addr(o_ribm_addr), .o_ribm_wrcs(o_ribm_wrcs), .o_ribm_mask(o_ribm_mask),
        .o_ribm_wdata(o_ribm_wdata), .i_ribm_rdata(i_ribm_rdata), .o_ribm_req(o_ribm_req),
        .i_ribm_gnt(i_ribm_gnt), .i_ribm_rsp(i_ribm_rsp), .o_ribm_rdy(o_ribm_rdy),
        .o_irq(o_irq)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Master-bus responder state and transaction log.
    int          gnt_dly = 0;
    int          rsp_dly = 0;
    int          cyc = 0;
    int          nrsp = 0;
    logic [31:0] wr_data [$];
    int          req_cyc [$];
    int          rsp_cyc [$];
    logic [31:0] tbl_m [8];

    initial begin : responder
        int          gcnt;
        int          rcnt;
        bit          in_req;
        logic [31:0] hold;
        gcnt = 0; rcnt = 0; in_req = 0; hold = '0;
        forever begin
            @(negedge clk);
            cyc++;
            i_ribm_gnt = 1'b0;
            i_ribm_rsp = 1'b0;
            if (!rstn) begin
                gcnt = 0; rcnt = 0; in_req = 0;
            end else begin
                if (o_ribm_req) begin
                    if (!in_req) begin
                        in_req = 1;
                        hold = o_ribm_wdata;
                        wr_data.push_back(o_ribm_wdata);
                        req_cyc.push_back(cyc);
                        check("m_addr", o_ribm_addr, 32'h8);
                        check("m_mask_wrcs", {27'd0, o_ribm_mask, o_ribm_wrcs}, 32'h1F);
                    end else begin
                        check("m_hold_wdata", o_ribm_wdata, hold);
                        check("m_hold_addr", o_ribm_addr, 32'h8);
                    end
                    if (gcnt >= gnt_dly) begin
                        i_ribm_gnt = 1'b1; gcnt = 0; in_req = 0;
                    end else gcnt++;
                end
                if (o_ribm_rdy) begin
                    if (rcnt >= rsp_dly) begin
                        i_ribm_rsp = 1'b1; rcnt = 0;
                        rsp_cyc.push_back(cyc);
                        nrsp++;
                    end else rcnt++;
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    task automatic reg_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        i_ribs_req = 1'b1; i_ribs_wrcs = 1'b1; i_ribs_addr = a; i_ribs_wdata = d; i_ribs_mask = 4'hF;
        @(negedge clk);
        i_ribs_req = 1'b0; i_ribs_wrcs = 1'b0;
    endtask

    task automatic reg_rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        i_ribs_req = 1'b1; i_ribs_wrcs = 1'b0; i_ribs_addr = a; i_ribs_mask = 4'hF;
        #1 check("s_gnt", {31'd0, o_ribs_gnt}, 32'd1);
        @(negedge clk);
        check("s_rsp", {31'd0, o_ribs_rsp}, 32'd1);
        d = o_ribs_rdata;
        i_ribs_req = 1'b0;
    endtask

    task automatic wait_idle();
        logic [31:0] st;
        bit ok;
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            reg_rd(A_STATUS, st);
            if (st[0] == 1'b0) begin ok = 1; break; end
        end
        check("idle_reached", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_rsp(input int n);
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (nrsp >= n) begin ok = 1; break; end
        end
        check("rsp_reached", {31'd0, ok}, 32'd1);
    endtask

    task automatic clear_log();
        wr_data.delete(); req_cyc.delete(); rsp_cyc.delete(); nrsp = 0;
    endtask

    task automatic load_table();
        for (int i = 0; i < 8; i++) reg_wr(A_TABLE + 32'(4 * i), tbl_m[i]);
    endtask

    // Reference: one-shot run writes the first effLEN entries, each later write
    // starting effINTERVAL+1 cycles after the previous response.
    task automatic run_oneshot(input int len, input int ivl, input int gd, input int rd);
        int          eff, effi;
        logic [31:0] v;
        eff  = (len == 0) ? 1 : ((len > 8) ? 8 : len);
        effi = (ivl == 0) ? 1 : ivl;
        gnt_dly = gd; rsp_dly = rd;
        clear_log();
        load_table();
        reg_wr(A_IVL, 32'(ivl));
        reg_wr(A_LEN, 32'(len));
        reg_wr(A_CTRL, 32'h1);
        wait_idle();
        check("n_writes", 32'(wr_data.size()), 32'(eff));
        for (int i = 0; i < wr_data.size() && i < eff; i++)
            check("wr_value", wr_data[i], tbl_m[i]);
        for (int i = 1; i < req_cyc.size() && i <= rsp_cyc.size(); i++)
            check("wr_gap", 32'(req_cyc[i] - rsp_cyc[i-1]), 32'(effi + 1));
        reg_rd(A_STATUS, v);
        check("status_done", v, (32'(eff - 1) << 4) | 32'h2);
        reg_rd(A_CTRL, v);
        check("ctrl_en_cleared", v, 32'h0);
        reg_wr(A_STATUS, 32'h2);
    endtask

    initial begin : main
        logic [31:0] v;
        int          nw;

        // Reset state
        #3 rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {28'd0, o_ribm_req, o_ribm_rdy, o_irq, o_ribs_rsp}, 32'h0);
        rstn = 1'b1;
        reg_rd(A_CTRL, v);   check("rst_ctrl", v, 32'h0);
        reg_rd(A_IVL, v);    check("rst_interval", v, 32'h0);
        reg_rd(A_LEN, v);    check("rst_len", v, 32'h0);
        reg_rd(A_STATUS, v); check("rst_status", v, 32'h0);
        reg_rd(A_TABLE, v);  check("rst_table0", v, 32'h0);
        reg_wr(32'h100, 32'hFFFF_FFFF);
        reg_rd(32'h100, v);  check("unmapped_rd", v, 32'h0);
        reg_wr(A_IVL, 32'hA5A5_1234);
        reg_rd(A_IVL, v);    check("interval_rw", v, 32'hA5A5_1234);

        // Directed one-shot: 10,20,30 with 4-cycle spacing
        for (int i = 0; i < 8; i++) tbl_m[i] = 32'(100 + i);
        tbl_m[0] = 32'd10; tbl_m[1] = 32'd20; tbl_m[2] = 32'd30;
        run_oneshot(3, 4, 0, 0);

        // Length boundaries
        for (int i = 0; i < 8; i++) tbl_m[i] = $urandom;
        run_oneshot(0, 0, 0, 0);
        run_oneshot(15, 1, 1, 1);

        // Randomized one-shot runs
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 8; i++) tbl_m[i] = $urandom;
            run_oneshot($urandom_range(0, 15), $urandom_range(0, 5),
                        $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Looping run, stopped by software while waiting
        tbl_m[0] = 32'd10; tbl_m[1] = 32'd20; tbl_m[2] = 32'd30;
        gnt_dly = 0; rsp_dly = 0;
        clear_log();
        load_table();
        reg_wr(A_IVL, 32'd4);
        reg_wr(A_LEN, 32'd3);
        reg_wr(A_CTRL, 32'h3);
        wait_rsp(5);
        reg_wr(A_CTRL, 32'h2);
        reg_rd(A_STATUS, v);
        check("loop_stop_idle", v & 32'h3, 32'h0);
        repeat (30) @(negedge clk);
        check("loop_n_writes", 32'(wr_data.size()), 32'd5);
        for (int i = 0; i < wr_data.size(); i++) check("loop_value", wr_data[i], tbl_m[i % 3]);
        for (int i = 1; i < req_cyc.size(); i++)
            check("loop_gap", 32'(req_cyc[i] - rsp_cyc[i-1]), 32'd5);

        // Grant held off 5 cycles; EN cleared while the request is pending
        for (int i = 0; i < 8; i++) tbl_m[i] = $urandom;
        gnt_dly = 5; rsp_dly = 0;
        clear_log();
        load_table();
        reg_wr(A_IVL, 32'd2);
        reg_wr(A_LEN, 32'd4);
        reg_wr(A_CTRL, 32'h1);
        begin
            bit ok;
            ok = 0;
            for (int i = 0; i < 3000; i++) begin
                @(posedge clk);
                if (wr_data.size() >= 2) begin ok = 1; break; end
            end
            check("second_req_seen", {31'd0, ok}, 32'd1);
        end
        reg_wr(A_CTRL, 32'h0);
        wait_idle();
        check("abort_n_writes", 32'(wr_data.size()), 32'd2);
        check("abort_value0", wr_data[0], tbl_m[0]);
        check("abort_value1", wr_data[1], tbl_m[1]);
        reg_rd(A_STATUS, v);
        check("abort_no_done", v & 32'h3, 32'h0);

        // DONE set and W1C in the same cycle, interrupt enabled
        gnt_dly = 0; rsp_dly = 0;
        clear_log();
        reg_wr(A_IVL, 32'd0);
        reg_wr(A_LEN, 32'd1);
        reg_wr(A_CTRL, 32'h5);
        begin
            bit ok;
            ok = 0;
            for (int i = 0; i < 3000; i++) begin
                @(negedge clk);
                if (o_ribm_rdy) begin ok = 1; break; end
            end
            check("rsp_phase_seen", {31'd0, ok}, 32'd1);
            i_ribs_req = 1'b1; i_ribs_wrcs = 1'b1; i_ribs_addr = A_STATUS; i_ribs_wdata = 32'h2;
            @(negedge clk);
            i_ribs_req = 1'b0; i_ribs_wrcs = 1'b0;
        end
        check("irq_set_wins", {31'd0, o_irq}, 32'd1);
        reg_rd(A_STATUS, v);
        check("done_set_wins", v & 32'h3, 32'h2);
        reg_wr(A_STATUS, 32'h2);
        check("irq_after_w1c", {31'd0, o_irq}, 32'd0);
        reg_rd(A_STATUS, v);
        check("done_after_w1c", v & 32'h3, 32'h0);

        // Reset asserted while waiting for the response
        for (int i = 0; i < 8; i++) tbl_m[i] = $urandom | 32'h1;
        gnt_dly = 0; rsp_dly = 40;
        clear_log();
        load_table();
        reg_wr(A_IVL, 32'd1);
        reg_wr(A_LEN, 32'd2);
        reg_wr(A_CTRL, 32'h7);
        begin
            bit ok;
            ok = 0;
            for (int i = 0; i < 3000; i++) begin
                @(negedge clk);
                if (o_ribm_rdy) begin ok = 1; break; end
            end
            check("rsp_phase_for_rst", {31'd0, ok}, 32'd1);
        end
        rstn = 1'b0;
        #1 check("rst_drops_master", {30'd0, o_ribm_req, o_ribm_rdy}, 32'h0);
        rsp_dly = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        nw = wr_data.size();
        reg_rd(A_CTRL, v);   check("post_rst_ctrl", v, 32'h0);
        reg_rd(A_IVL, v);    check("post_rst_interval", v, 32'h0);
        reg_rd(A_LEN, v);    check("post_rst_len", v, 32'h0);
        reg_rd(A_STATUS, v); check("post_rst_status", v, 32'h0);
        reg_rd(A_TABLE, v);  check("post_rst_table0", v, 32'h0);
        reg_rd(A_TABLE + 32'h4, v); check("post_rst_table1", v, 32'h0);
        repeat (20) @(negedge clk);
        check("post_rst_no_resume", 32'(wr_data.size()), 32'(nw));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
